complete_arbiter: RTL and testbench
===================================

# complete_arbiter

Complete-stage arbiter between the functional units and the common data bus. Each cycle it collects up to `NUM_FU` finished `FU_COMPLETE_PACKET`s, grants at most `CDB_W` of them onto registered CDB slots, and drives `complete_stall` back to every losing FU so that FU holds its result. The branch FU has fixed top priority; all other FUs share round-robin fairness. Mispredict squash flushes the CDB registers.

## Interface
- `NUM_FU`, 8: number of FUs; bit order fixed by `FU_STATE_PACKET` (bit 0 = branch).
- `CDB_W`, 2: CDB slots per cycle; 1 ≤ `CDB_W` ≤ `NUM_FU`.
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `want_to_complete`  in  `FU_STATE_PACKET`  per-FU request, level, held until granted.
- `fu_packet_in`  in  `FU_COMPLETE_PACKET [NUM_FU]`  per-FU result; sampled only where the request bit is 1.
- `squash`  in  1  mispredict recovery from retire.
- `complete_stall`  out  `FU_STATE_PACKET`  combinational; 1 = FU requested and lost this cycle and must hold.
- `cdb_packet`  out  `FU_COMPLETE_PACKET [CDB_W]`  registered CDB slots to ROB, RS wakeup, and map table.
- `cdb_valid`  out  `CDB_W`  registered, one bit per slot.

## Operation
- Grant order each cycle: the branch FU first if it is requesting. Remaining slots go to the other FUs in round-robin order, starting at `rr_ptr` and scanning upward with wrap-around over indices 1..`NUM_FU-1`.
- Granted FUs fill slots in grant order: slot 0 first, lowest grant order.
- `complete_stall[i] = want_to_complete[i] & ~grant[i]`. Non-requesting FUs always see 0.
- `rr_ptr` (reset 1) advances to one past the last granted non-branch index, wrapping from `NUM_FU-1` to 1. It is unchanged if no non-branch FU is granted.
- Packets with `halt=1` arbitrate like any other packet.
- Squash has priority over everything:
  - In the squash cycle, all `cdb_valid` clear next edge and all grants are forced to 0.
  - `complete_stall` = 0 for all FUs, because the FUs flush on `squash` themselves.
  - `rr_ptr` is held.
- No request: slots go invalid next edge. The `cdb_packet` contents are don't-care when invalid.

## Timing
- Grant and stall are combinational in the request cycle. The result appears on `cdb_packet`/`cdb_valid` after exactly one posedge.
- An FU whose stall is high keeps `want_to_complete` and its packet stable. It may retry in the next cycle.
- Full case: requests exceed `CDB_W`. Exactly `CDB_W` are granted; the rest stall.
- Starvation bound: a non-branch requester is granted within `ceil((NUM_FU-1)/CDB_W)+1` cycles, provided the branch FU does not request continuously.
- Reset (asynchronous, mid-operation allowed):
  - `cdb_valid` = 0, `cdb_packet` = 0, `rr_ptr` = 1.
  - `complete_stall` is derived from inputs and is therefore 0 only once requests drop.

## Structure
- `sys_defs` package holds the shared types and constants:
  - `FU_STATE_PACKET` as a packed `NUM_FU`-bit struct;
  - `FU_COMPLETE_PACKET` (`if_take_branch`, `valid`, `halt`, `target_pc`, `dest_pr`, `dest_value`, `rob_entry`);
  - `NUM_FU`, `CDB_W`, and the FU index constants.
- One sub-module is natural: `rr_picker`, a combinational rotate-priority picker that returns up to `CDB_W` one-hot grants given a request vector and a start pointer. The top level holds `rr_ptr`, the branch override, slot packing, and the output registers.

## Test plan
- Single branch request:
  - Stimulus: branch requests with `rob_entry=0`, `dest_pr=32`, `if_take_branch=1`; nothing else requests.
  - Response: `complete_stall` = 0; next edge `cdb_valid=01`, slot 0 carries `dest_pr=32`, `rob_entry=0`.
- Overflow:
  - Stimulus: FUs 1, 2, 3 request with `rr_ptr=1`.
  - Response: FUs 1 and 2 granted (slots 0 and 1); `complete_stall` = 0b01000; `rr_ptr` becomes 3. Next cycle FU 3 is granted in slot 0.
- Branch override:
  - Stimulus: branch plus FUs 4, 5, 6 request with `rr_ptr=5`.
  - Response: slot 0 = branch, slot 1 = FU 5; FUs 4 and 6 stall; `rr_ptr` becomes 6.
- Wrap-around:
  - Stimulus: `rr_ptr=7`; FUs 1 and 7 request.
  - Response: slot 0 = FU 7, slot 1 = FU 1; `rr_ptr` becomes 2.
- Squash:
  - Stimulus: 2 valid slots in flight; `squash=1` with FUs 2 and 3 requesting.
  - Response: next edge `cdb_valid=00`; `complete_stall` = 0; `rr_ptr` unchanged.
- Reset mid-operation:
  - Stimulus: `reset` pulled low between edges while `cdb_valid=11`.
  - Response: `cdb_valid` = 00 immediately, without waiting for a clock edge; `rr_ptr=1` after release.

Source files
------------

// File: rtl/complete_arbiter_pkg.sv
// Shared types and constants for the complete stage and the common data bus.
package sys_defs;

    localparam int NUM_FU      = 8;
    localparam int CDB_W       = 2;
    localparam int IDX_W       = $clog2(NUM_FU);
    localparam int CNT_W       = $clog2(CDB_W + 1);
    localparam int PC_W        = 32;
    localparam int PR_W        = 6;
    localparam int DATA_W      = 32;
    localparam int ROB_W       = 5;

    // FU index constants; bit 0 is always the branch unit
    localparam int FU_BRANCH   = 0;
    localparam int FU_ALU_1    = 1;
    localparam int FU_ALU_2    = 2;
    localparam int FU_ALU_3    = 3;
    localparam int FU_STORE    = 4;
    localparam int FU_LOAD     = 5;
    localparam int FU_MULT_0   = 6;
    localparam int FU_MULT_1   = 7;

    // First member is the MSB, so declaration order is the reverse of index order
    typedef struct packed {
        logic mult_1;
        logic mult_0;
        logic load;
        logic store;
        logic alu_3;
        logic alu_2;
        logic alu_1;
        logic branch;
    } FU_STATE_PACKET;

    typedef struct packed {
        logic              if_take_branch;
        logic              valid;
        logic              halt;
        logic [PC_W-1:0]   target_pc;
        logic [PR_W-1:0]   dest_pr;
        logic [DATA_W-1:0] dest_value;
        logic [ROB_W-1:0]  rob_entry;
    } FU_COMPLETE_PACKET;

    // Round-robin successor over indices 1..NUM_FU-1 (index 0 is never in the ring)
    function automatic logic [IDX_W-1:0] rr_next_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) >= NUM_FU - 1) begin
            return IDX_W'(1);
        end
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/complete_arbiter_rr_picker.sv
// Combinational rotate-priority picker: scans the non-branch ring starting at
// start_ptr and returns up to max_grants one-hot grants in scan order.
module rr_picker
    import sys_defs::*;
(
    input  logic [NUM_FU-1:0] req,
    input  logic [IDX_W-1:0]  start_ptr,
    input  logic [CNT_W-1:0]  max_grants,
    output logic [NUM_FU-1:0] grant_oh [CDB_W],
    output logic [IDX_W-1:0]  grant_idx [CDB_W],
    output logic [CDB_W-1:0]  grant_vld,
    output logic              any_grant,
    output logic [IDX_W-1:0]  last_idx
);

    logic [NUM_FU-1:0] ring_req;

    // The branch unit is arbitrated by the caller, never by the ring
    assign ring_req = req & ~NUM_FU'(1);

    // Walk the ring once, handing out grants in rank order until the budget runs out
    always_comb begin
        int cnt;
        int pos;
        cnt       = 0;
        pos       = 0;
        any_grant = 1'b0;
        last_idx  = '0;
        grant_vld = '0;
        for (int r = 0; r < CDB_W; r++) begin
            grant_oh[r]  = '0;
            grant_idx[r] = '0;
        end
        for (int k = 0; k < NUM_FU - 1; k++) begin
            pos = int'(start_ptr) + k;
            if (pos >= NUM_FU) begin
                pos = pos - (NUM_FU - 1);
            end
            if (ring_req[pos] && (cnt < int'(max_grants))) begin
                grant_oh[cnt][pos] = 1'b1;
                grant_idx[cnt]     = IDX_W'(pos);
                grant_vld[cnt]     = 1'b1;
                any_grant          = 1'b1;
                last_idx           = IDX_W'(pos);
                cnt                = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/complete_arbiter.sv
// Complete-stage arbiter: branch unit has fixed top priority, the remaining
// FUs share the CDB slots round-robin. Winners are registered onto the CDB,
// losers are told to hold via complete_stall. Squash flushes the CDB.
module complete_arbiter
    import sys_defs::*;
(
    input  logic              clock,
    input  logic              reset,
    input  FU_STATE_PACKET    want_to_complete,
    input  FU_COMPLETE_PACKET fu_packet_in [NUM_FU],
    input  logic              squash,
    output FU_STATE_PACKET    complete_stall,
    output FU_COMPLETE_PACKET cdb_packet [CDB_W],
    output logic [CDB_W-1:0]  cdb_valid
);

    logic [NUM_FU-1:0] want_vec;
    logic [NUM_FU-1:0] pick_req;
    logic [NUM_FU-1:0] grant_vec;
    logic [NUM_FU-1:0] stall_vec;
    logic              branch_req;
    logic [CNT_W-1:0]  max_grants;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  rr_ptr_next;

    logic [NUM_FU-1:0] pick_oh [CDB_W];
    logic [IDX_W-1:0]  pick_idx [CDB_W];
    logic [CDB_W-1:0]  pick_vld;
    logic              pick_any;
    logic [IDX_W-1:0]  pick_last;

    logic [IDX_W-1:0]  slot_idx [CDB_W];
    logic [CDB_W-1:0]  slot_vld;

    assign want_vec   = want_to_complete;
    assign branch_req = want_vec[FU_BRANCH] & ~squash;
    assign pick_req   = squash ? '0 : want_vec;
    assign max_grants = CNT_W'(CDB_W) - CNT_W'(branch_req);

    rr_picker u_rr_picker (
        .req        (pick_req),
        .start_ptr  (rr_ptr),
        .max_grants (max_grants),
        .grant_oh   (pick_oh),
        .grant_idx  (pick_idx),
        .grant_vld  (pick_vld),
        .any_grant  (pick_any),
        .last_idx   (pick_last)
    );

    // Pack winners into slots: branch takes slot 0, ring winners follow in rank order
    always_comb begin
        slot_vld = '0;
        for (int s = 0; s < CDB_W; s++) begin
            slot_idx[s] = '0;
        end
        if (branch_req) begin
            slot_vld[0] = 1'b1;
            slot_idx[0] = IDX_W'(FU_BRANCH);
        end else begin
            slot_vld[0] = pick_vld[0];
            slot_idx[0] = pick_idx[0];
        end
        for (int s = 1; s < CDB_W; s++) begin
            if (branch_req) begin
                slot_vld[s] = pick_vld[s-1];
                slot_idx[s] = pick_idx[s-1];
            end else begin
                slot_vld[s] = pick_vld[s];
                slot_idx[s] = pick_idx[s];
            end
        end
    end

    // Merge the one-hot grants into a per-FU grant vector
    always_comb begin
        grant_vec            = '0;
        grant_vec[FU_BRANCH] = branch_req;
        for (int r = 0; r < CDB_W; r++) begin
            grant_vec = grant_vec | pick_oh[r];
        end
    end

    // FUs flush themselves on squash, so nobody is told to hold in that cycle
    assign stall_vec      = squash ? '0 : (want_vec & ~grant_vec);
    assign complete_stall = FU_STATE_PACKET'(stall_vec);

    // Pointer moves past the last ring winner; with no ring winner it stays put
    assign rr_ptr_next = pick_any ? rr_next_idx(pick_last) : rr_ptr;

    // Register the CDB slots and the round-robin pointer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= IDX_W'(1);
            cdb_valid <= '0;
            for (int s = 0; s < CDB_W; s++) begin
                cdb_packet[s] <= '0;
            end
        end else begin
            rr_ptr    <= rr_ptr_next;
            cdb_valid <= slot_vld;
            for (int s = 0; s < CDB_W; s++) begin
                if (slot_vld[s]) begin
                    cdb_packet[s] <= fu_packet_in[slot_idx[s]];
                end
            end
        end
    end

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed bench for complete_arbiter: a table of back-to-back request
// vectors with hand-computed results, then squash, halt and reset sequences.
module tb_complete_arbiter;
    import sys_defs::*;

    logic              clock;
    logic              reset;
    FU_STATE_PACKET    want_to_complete;
    FU_COMPLETE_PACKET fu_packet_in [NUM_FU];
    logic              squash;
    FU_STATE_PACKET    complete_stall;
    FU_COMPLETE_PACKET cdb_packet [CDB_W];
    logic [CDB_W-1:0]  cdb_valid;

    int n_checks = 0;
    int n_errors = 0;

    complete_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .want_to_complete (want_to_complete),
        .fu_packet_in     (fu_packet_in),
        .squash           (squash),
        .complete_stall   (complete_stall),
        .cdb_packet       (cdb_packet),
        .cdb_valid        (cdb_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] want;
        logic [7:0] exp_stall;
        logic [1:0] exp_valid;
        logic [4:0] exp_s0;
        logic [4:0] exp_s1;
        logic [2:0] exp_rr;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] w, input logic [7:0] st, input logic [1:0] v,
                                input logic [4:0] s0, input logic [4:0] s1, input logic [2:0] rr);
        vec_t t;
        t.want = w; t.exp_stall = st; t.exp_valid = v;
        t.exp_s0 = s0; t.exp_s1 = s1; t.exp_rr = rr;
        return t;
    endfunction

    // Drive on the falling edge, check stall combinationally, then check registered outputs after the rising edge
    task automatic step(input string tag, input logic [7:0] w, input logic sq,
                        input logic [7:0] exp_stall, input logic [1:0] exp_valid,
                        input logic [4:0] s0, input logic [4:0] s1, input logic [2:0] rr);
        @(negedge clock);
        want_to_complete = FU_STATE_PACKET'(w);
        squash = sq;
        #1;
        chk({tag, " stall"}, 32'(complete_stall), 32'(exp_stall));
        @(posedge clock);
        #1;
        chk({tag, " valid"}, 32'(cdb_valid), 32'(exp_valid));
        if (exp_valid[0]) chk({tag, " slot0 rob"}, 32'(cdb_packet[0].rob_entry), 32'(s0));
        if (exp_valid[1]) chk({tag, " slot1 rob"}, 32'(cdb_packet[1].rob_entry), 32'(s1));
        chk({tag, " rr_ptr"}, 32'(dut.rr_ptr), 32'(rr));
    endtask

    initial begin
        reset = 1'b0;
        squash = 1'b0;
        want_to_complete = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_packet_in[i] = '0;
            fu_packet_in[i].valid      = 1'b1;
            fu_packet_in[i].rob_entry  = ROB_W'(i);
            fu_packet_in[i].dest_pr    = PR_W'(32 + i);
            fu_packet_in[i].dest_value = 32'h1000 + 32'(i);
            fu_packet_in[i].target_pc  = 32'h400 + 32'(i * 4);
        end
        fu_packet_in[0].if_take_branch = 1'b1;

        //             want   stall  valid s0 s1 rr
        vecs[0]  = mk(8'h01, 8'h00, 2'b01, 0, 0, 1);  // lone branch
        vecs[1]  = mk(8'h0E, 8'h08, 2'b11, 1, 2, 3);  // overflow, FU3 loses
        vecs[2]  = mk(8'h08, 8'h00, 2'b01, 3, 0, 4);  // FU3 retries
        vecs[3]  = mk(8'h10, 8'h00, 2'b01, 4, 0, 5);
        vecs[4]  = mk(8'h71, 8'h50, 2'b11, 0, 5, 6);  // branch override at rr=5
        vecs[5]  = mk(8'h50, 8'h00, 2'b11, 6, 4, 5);
        vecs[6]  = mk(8'h40, 8'h00, 2'b01, 6, 0, 7);
        vecs[7]  = mk(8'h82, 8'h00, 2'b11, 7, 1, 2);  // wrap-around
        vecs[8]  = mk(8'h00, 8'h00, 2'b00, 0, 0, 2);  // idle
        vecs[9]  = mk(8'hFE, 8'hF2, 2'b11, 2, 3, 4);  // all ring FUs request
        vecs[10] = mk(8'hF2, 8'hC2, 2'b11, 4, 5, 6);
        vecs[11] = mk(8'hC2, 8'h02, 2'b11, 6, 7, 1);
        vecs[12] = mk(8'h02, 8'h00, 2'b01, 1, 0, 2);  // FU1 served within bound

        #12;
        chk("reset valid", 32'(cdb_valid), 32'h0);
        chk("reset slot0", 32'(cdb_packet[0].rob_entry), 32'h0);
        chk("reset rr_ptr", 32'(dut.rr_ptr), 32'h1);
        @(negedge clock);
        reset = 1'b1;

        for (int v = 0; v < 13; v++) begin
            step($sformatf("vec%0d", v), vecs[v].want, 1'b0, vecs[v].exp_stall,
                 vecs[v].exp_valid, vecs[v].exp_s0, vecs[v].exp_s1, vecs[v].exp_rr);
            if (v == 0) begin
                chk("branch dest_pr", 32'(cdb_packet[0].dest_pr), 32'd32);
                chk("branch taken", 32'(cdb_packet[0].if_take_branch), 32'd1);
            end
        end

        // Squash with two slots in flight: CDB flushes, no stalls, pointer held
        step("pre-squash", 8'h06, 1'b0, 8'h00, 2'b11, 2, 1, 2);
        step("squash", 8'h0C, 1'b1, 8'h00, 2'b00, 0, 0, 2);

        // Halt packet goes through like any other
        fu_packet_in[3].halt = 1'b1;
        step("halt", 8'h08, 1'b0, 8'h00, 2'b01, 3, 0, 4);
        chk("halt bit", 32'(cdb_packet[0].halt), 32'd1);
        fu_packet_in[3].halt = 1'b0;

        // Reset between edges while both slots are valid
        step("pre-reset", 8'h30, 1'b0, 8'h00, 2'b11, 4, 5, 6);
        @(negedge clock);
        want_to_complete = '0;
        #2;
        reset = 1'b0;
        #1;
        chk("async reset valid", 32'(cdb_valid), 32'h0);
        chk("async reset pkt", 32'(cdb_packet[1].rob_entry), 32'h0);
        chk("async reset rr", 32'(dut.rr_ptr), 32'h1);
        @(negedge clock);
        reset = 1'b1;
        step("post-reset", 8'h00, 1'b0, 8'h00, 2'b00, 0, 0, 1);
        step("post-reset rr", 8'h06, 1'b0, 8'h00, 2'b11, 1, 2, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
